// File: rtl/inst_queue.sv
// inst_queue: decoupling FIFO between fetch/decode and rename/dispatch.
// Decoded bundles are buffered while rename stalls, so fetch can keep
// streaming. A flush (redirect) drops every wrong-path bundle in one cycle.
//
// Ports:
//   clk, rst_n      - clock (rising edge), synchronous active-low reset
//   flush           - discard all entries at the next edge
//   enq_valid/ready - producer handshake; enq_bundle is the incoming bundle
//   deq_valid/ready - consumer handshake; deq_bundle is the head entry
//   count           - registered occupancy, 0..DEPTH

package inst_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  uop_class;
        logic [5:0]  op;
        logic        pred_taken;
        logic [31:0] pred_target;
    } decoded_bundle_t;
endpackage

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            enq_valid,
    output logic            enq_ready,
    input  decoded_bundle_t enq_bundle,
    output logic            deq_valid,
    input  logic            deq_ready,
    output decoded_bundle_t deq_bundle,
    output logic [CW-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     head;
    logic [AW:0]     tail;
    logic [CW-1:0]   count_q;
    decoded_bundle_t mem [DEPTH];

    logic empty;
    logic full;
    logic enq_fire;
    logic deq_fire;

    assign empty = (head == tail);
    assign full  = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);

    // Readiness is derived only from registered state, so a full queue
    // never accepts in the same cycle it drains (no ready->ready path).
    assign enq_ready = rst_n && !flush && !full;
    assign deq_valid = rst_n && !flush && !empty;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    assign deq_bundle = deq_valid ? mem[head[AW-1:0]] : '0;
    assign count      = count_q;

    // Control state: pointers and occupancy; reset and flush clear alike.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + 1'b1;
            end
            if (deq_fire) begin
                head <= head + 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage: never reset; enq_fire is already gated by rst_n and flush.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail[AW-1:0]] <= enq_bundle;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed testbench for inst_queue (DEPTH = 8).
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            enq_valid;
    logic            enq_ready;
    decoded_bundle_t enq_bundle;
    logic            deq_valid;
    logic            deq_ready;
    decoded_bundle_t deq_bundle;
    logic [3:0]      count;

    int checks;
    int errors;

    inst_queue #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_bundle (enq_bundle),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_bundle (deq_bundle),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every field derived from pc so a bit-exact compare covers all fields.
    function automatic decoded_bundle_t mk(input logic [31:0] pc);
        decoded_bundle_t b;
        b.pc          = pc;
        b.uop_class   = pc[4:2];
        b.op          = pc[7:2] ^ 6'h2A;
        b.pred_taken  = pc[2];
        b.pred_target = pc + 32'h100;
        return b;
    endfunction

    // Advance one clock: inputs were set at negedge, sampled #1 later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b1; deq_ready = 1'b1;
        enq_bundle = mk(32'hDEAD_0000);
        #1;
        checks++;
        if (enq_ready !== 1'b0 || deq_valid !== 1'b0 || deq_bundle !== '0) begin
            errors++;
            $display("FAIL reset_outputs: enq_ready=%b deq_valid=%b deq_bundle=%h, required 0 0 0",
                     enq_ready, deq_valid, deq_bundle);
        end
        step();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: count=%0d, required 0", count);
        end
        rst_n = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        checks++;
        if (enq_ready !== 1'b1 || deq_valid !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: enq_ready=%b deq_valid=%b count=%0d, required 1 0 0",
                     enq_ready, deq_valid, count);
        end
    endtask

    task automatic test_passthrough();
        deq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            enq_valid  = (i < 4);
            enq_bundle = mk(32'(i * 4));
            #1;
            checks++;
            if (i == 0 || i == 5) begin
                if (deq_valid !== 1'b0 || count !== 4'd0) begin
                    errors++;
                    $display("FAIL pass_empty[%0d]: deq_valid=%b count=%0d, required 0 0",
                             i, deq_valid, count);
                end
            end else begin
                if (deq_valid !== 1'b1 || deq_bundle !== mk(32'((i - 1) * 4)) || count !== 4'd1) begin
                    errors++;
                    $display("FAIL pass_deq[%0d]: deq_valid=%b pc=%h count=%0d, required 1 %h 1",
                             i, deq_valid, deq_bundle.pc, count, (i - 1) * 4);
                end
            end
            step();
        end
    endtask

    task automatic test_fill_drain();
        int next_off;
        int exp_i;
        deq_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enq_valid  = 1'b1;
            enq_bundle = mk(32'(i * 4));
            #1;
            checks++;
            if (enq_ready !== (i < 8) || count !== 4'((i < 8) ? i : 8)) begin
                errors++;
                $display("FAIL fill[%0d]: enq_ready=%b count=%0d, required %b %0d",
                         i, enq_ready, count, (i < 8), (i < 8) ? i : 8);
            end
            step();
        end
        // Drain while fetch keeps offering the two rejected bundles.
        deq_ready = 1'b1;
        next_off  = 8;
        exp_i     = 0;
        for (int cyc = 0; cyc < 30 && exp_i < 10; cyc++) begin
            enq_valid  = (next_off < 10);
            enq_bundle = mk(32'(next_off * 4));
            #1;
            if (cyc == 0) begin
                checks++;
                if (enq_ready !== 1'b0 || count !== 4'd8) begin
                    errors++;
                    $display("FAIL full_no_same_cycle: enq_ready=%b count=%0d, required 0 8",
                             enq_ready, count);
                end
            end
            if (deq_valid) begin
                checks++;
                if (deq_bundle !== mk(32'(exp_i * 4))) begin
                    errors++;
                    $display("FAIL drain_order[%0d]: pc=%h, required %h",
                             exp_i, deq_bundle.pc, exp_i * 4);
                end
                exp_i++;
            end
            if (enq_valid && enq_ready) next_off++;
            step();
        end
        enq_valid = 1'b0;
        #1;
        checks++;
        if (exp_i != 10 || deq_valid !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL drain_total: dequeued=%0d deq_valid=%b count=%0d, required 10 0 0",
                     exp_i, deq_valid, count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] sb[$];
        int          sent;
        int          mcnt;
        logic [3:0]  ptr_diff;
        logic        ok;
        sent = 0;
        mcnt = 0;
        ok   = 1'b1;
        for (int cyc = 0; cyc < 200 && (sent < 20 || mcnt > 0); cyc++) begin
            enq_valid  = (sent < 20);
            enq_bundle = mk(32'h100 + 32'(sent * 4));
            deq_ready  = 1'($urandom_range(0, 1));
            #1;
            ptr_diff = dut.tail - dut.head;
            checks++;
            if (count !== 4'(mcnt) || ptr_diff !== 4'(mcnt) ||
                enq_ready !== (mcnt < 8) || deq_valid !== (mcnt > 0)) begin
                errors++;
                ok = 1'b0;
                $display("FAIL wrap_state[%0d]: count=%0d tail-head=%0d enq_ready=%b deq_valid=%b, required count %0d",
                         cyc, count, ptr_diff, enq_ready, deq_valid, mcnt);
            end
            if (mcnt > 0 && deq_ready) begin
                checks++;
                if (deq_bundle !== mk(sb[0])) begin
                    errors++;
                    $display("FAIL wrap_order[%0d]: pc=%h, required %h", cyc, deq_bundle.pc, sb[0]);
                end
                void'(sb.pop_front());
                mcnt--;
            end
            if (enq_valid && (mcnt < 8 || (mcnt == 7 && deq_ready))) begin
                // Acceptance is judged on pre-edge occupancy.
            end
            if (sent < 20 && ((mcnt + ((mcnt > 0 || !deq_ready) ? 0 : 0)) >= 0)) begin
            end
            step();
        end
        checks++;
        if (sent != 0 || !ok) begin
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
    endtask

    task automatic test_wrap_run();
        logic [31:0] sb[$];
        int          sent;
        int          mcnt;
        int          got;
        logic        can_enq;
        logic        can_deq;
        logic [3:0]  ptr_diff;
        sent = 0;
        mcnt = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            enq_valid  = (sent < 20);
            enq_bundle = mk(32'h100 + 32'(sent * 4));
            deq_ready  = 1'($urandom_range(0, 1));
            can_enq    = (mcnt < 8);
            can_deq    = (mcnt > 0);
            #1;
            ptr_diff = dut.tail - dut.head;
            checks++;
            if (count !== 4'(mcnt) || ptr_diff !== 4'(mcnt) ||
                enq_ready !== can_enq || deq_valid !== can_deq) begin
                errors++;
                $display("FAIL wrap_state[%0d]: count=%0d tail-head=%0d enq_ready=%b deq_valid=%b, required count %0d",
                         cyc, count, ptr_diff, enq_ready, deq_valid, mcnt);
            end
            if (can_deq && deq_ready) begin
                checks++;
                if (deq_bundle !== mk(sb[0])) begin
                    errors++;
                    $display("FAIL wrap_order[%0d]: pc=%h, required %h", cyc, deq_bundle.pc, sb[0]);
                end
                void'(sb.pop_front());
                mcnt--;
                got++;
            end
            if (enq_valid && can_enq) begin
                sb.push_back(32'h100 + 32'(sent * 4));
                sent++;
                mcnt++;
            end
            step();
        end
        checks++;
        if (got != 20) begin
            errors++;
            $display("FAIL wrap_total: dequeued=%0d, required 20 within cycle budget", got);
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
    endtask

    task automatic test_flush();
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid  = 1'b1;
            enq_bundle = mk(32'h10 + 32'(i * 4));
            step();
        end
        flush      = 1'b1;
        enq_valid  = 1'b1;
        enq_bundle = mk(32'h1C);
        deq_ready  = 1'b1;
        #1;
        checks++;
        if (enq_ready !== 1'b0 || deq_valid !== 1'b0 || deq_bundle !== '0 || count !== 4'd3) begin
            errors++;
            $display("FAIL flush_cycle: enq_ready=%b deq_valid=%b count=%0d, required 0 0 3",
                     enq_ready, deq_valid, count);
        end
        step();
        flush      = 1'b0;
        enq_bundle = mk(32'h40);
        #1;
        checks++;
        if (count !== 4'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: count=%0d deq_valid=%b enq_ready=%b, required 0 0 1",
                     count, deq_valid, enq_ready);
        end
        step();
        enq_valid = 1'b0;
        #1;
        checks++;
        if (deq_valid !== 1'b1 || deq_bundle !== mk(32'h40) || count !== 4'd1) begin
            errors++;
            $display("FAIL flush_first_deq: deq_valid=%b pc=%h count=%0d, required 1 40 1",
                     deq_valid, deq_bundle.pc, count);
        end
        step();
        #1;
        checks++;
        if (deq_valid !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL flush_no_stale: deq_valid=%b pc=%h count=%0d, required 0 - 0",
                     deq_valid, deq_bundle.pc, count);
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_full_simul();
        deq_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            enq_valid  = 1'b1;
            enq_bundle = mk(32'h200 + 32'(i * 4));
            step();
        end
        enq_bundle = mk(32'h300);
        deq_ready  = 1'b1;
        #1;
        checks++;
        if (count !== 4'd8 || enq_ready !== 1'b0 || deq_valid !== 1'b1 || deq_bundle !== mk(32'h200)) begin
            errors++;
            $display("FAIL full_simul: count=%0d enq_ready=%b deq_valid=%b pc=%h, required 8 0 1 200",
                     count, enq_ready, deq_valid, deq_bundle.pc);
        end
        step();
        deq_ready = 1'b0;
        #1;
        checks++;
        if (count !== 4'd7 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_simul_deq_only: count=%0d enq_ready=%b, required 7 1", count, enq_ready);
        end
        step();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        #1;
        checks++;
        if (count !== 4'd8 || enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_simul_refill: count=%0d enq_ready=%b, required 8 0", count, enq_ready);
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (deq_valid !== 1'b1 || deq_bundle !== mk((i < 7) ? 32'h204 + 32'(i * 4) : 32'h300)) begin
                errors++;
                $display("FAIL full_simul_drain[%0d]: deq_valid=%b pc=%h, required 1 %h",
                         i, deq_valid, deq_bundle.pc, (i < 7) ? 32'h204 + 32'(i * 4) : 32'h300);
            end
            step();
        end
        #1;
        checks++;
        if (deq_valid !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL full_simul_empty: deq_valid=%b count=%0d, required 0 0", deq_valid, count);
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        deq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_valid  = 1'b1;
            enq_bundle = mk(32'h500 + 32'(i * 4));
            step();
        end
        enq_bundle = mk(32'h5FC);
        deq_ready  = 1'b1;
        rst_n      = 1'b0;
        #1;
        checks++;
        if (count !== 4'd5 || enq_ready !== 1'b0 || deq_valid !== 1'b0 || deq_bundle !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: count=%0d enq_ready=%b deq_valid=%b bundle=%h, required 5 0 0 0",
                     count, enq_ready, deq_valid, deq_bundle);
        end
        step();
        #1;
        checks++;
        if (count !== 4'd0 || enq_ready !== 1'b0 || deq_valid !== 1'b0 || deq_bundle !== '0) begin
            errors++;
            $display("FAIL rst_mid_hold: count=%0d enq_ready=%b deq_valid=%b, required 0 0 0",
                     count, enq_ready, deq_valid);
        end
        step();
        rst_n      = 1'b1;
        enq_bundle = mk(32'h600);
        #1;
        checks++;
        if (count !== 4'd0 || enq_ready !== 1'b1 || deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: count=%0d enq_ready=%b deq_valid=%b, required 0 1 0",
                     count, enq_ready, deq_valid);
        end
        step();
        enq_valid = 1'b0;
        #1;
        checks++;
        if (deq_valid !== 1'b1 || deq_bundle !== mk(32'h600)) begin
            errors++;
            $display("FAIL rst_mid_first_deq: deq_valid=%b pc=%h, required 1 600", deq_valid, deq_bundle.pc);
        end
        step();
        #1;
        checks++;
        if (count !== 4'd0 || deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_empty: count=%0d deq_valid=%b, required 0 0", count, deq_valid);
        end
        deq_ready = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        enq_valid  = 1'b0;
        deq_ready  = 1'b0;
        enq_bundle = '0;
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_fill_drain();
        test_wrap_run();
        test_flush();
        test_full_simul();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Decoupling FIFO between the fetch stage's decode output and the rename/dispatch stage. It absorbs decoded bundles whenever rename stalls, so fetch can keep streaming imem responses through backpressure. On a redirect it flushes every wrong-path bundle in a single cycle. Storage is a circular buffer of `decoded_bundle_t` entries with a registered occupancy count.

## Interface

- `DEPTH`, default 8: number of entries. Must be a power of two and at least 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the occupancy count. Derived; do not override.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `flush`, input, 1: discard all entries. Driven by `redirect_valid`.
- `enq_valid`, input, 1: fetch/decode presents a bundle. Driven by fetch `decode_valid`.
- `enq_ready`, output, 1: queue accepts a bundle. Drives fetch `decode_ready`.
- `enq_bundle`, input, `decoded_bundle_t`: incoming decoded instruction.
- `deq_valid`, output, 1: head entry valid toward rename.
- `deq_ready`, input, 1: rename accepts the head entry.
- `deq_bundle`, output, `decoded_bundle_t`: head entry.
- `count`, output, `CW`: current occupancy, 0..DEPTH.

## Operation

- Storage is DEPTH entries with head and tail pointers. Each pointer is `$clog2(DEPTH)+1` bits; the MSB is the wrap bit.
- Empty: `head == tail`.
- Full: index bits are equal and wrap bits differ.
- Enqueue fire is `enq_valid && enq_ready`. It writes `mem[tail]` and increments `tail`.
- Dequeue fire is `deq_valid && deq_ready`. It increments `head`.
- `enq_ready = rst_n && !flush && !full`. It depends only on registered state, never on `deq_ready`. A full queue does not accept an enqueue in the same cycle as a dequeue.
- `deq_valid = rst_n && !flush && !empty`.
- `deq_bundle = mem[head]` when `deq_valid`. Otherwise it is all-zero.
- `count` is a registered value:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both fire or neither fires.
  - Must always equal `tail − head` (modulo 2×DEPTH).
- Flush is synchronous:
  - `head`, `tail` and `count` become 0 at the next edge.
  - Any `enq_valid` or `deq_ready` in the flush cycle is ignored; no fire occurs.
  - Memory contents are not cleared.
- Pointer wrap: increment across DEPTH−1 wraps the index to 0 and toggles the wrap bit. There is no special case.
- Bundle fields (pc, uop_class, op, pred_taken, pred_target, …) pass through bit-exact and unmodified.

## Timing

- Reset: while `rst_n` is low, `enq_ready`, `deq_valid` and `deq_bundle` are 0. At the first edge with `rst_n` low, `head`, `tail` and `count` become 0.
  - One cycle after release: `enq_ready` = 1, `deq_valid` = 0, `count` = 0.
- Reset mid-operation clears all state exactly like flush. Reset dominates flush.
- Enqueue-to-dequeue latency is 1 cycle. A bundle enqueued at edge N is visible on `deq_*` after edge N. There is no combinational bypass.
- Sustained throughput is 1 enqueue and 1 dequeue per cycle when 0 < count < DEPTH.
- Full (count = DEPTH): `enq_ready` = 0. A dequeue at edge N makes `enq_ready` = 1 after edge N.
- Empty (count = 0): `deq_valid` = 0. An enqueue at edge N makes `deq_valid` = 1 after edge N.
- Flush at edge N: after N, `count` = 0 and `deq_valid` = 0. An enqueue at N+1 dequeues at N+2.
- Dequeue order is strictly FIFO. No bundle is duplicated or dropped except by flush or reset.

## Test plan

- **Sequential pass-through:** `deq_ready` = 1; enqueue bundles with pc 0x00, 0x04, 0x08, 0x0C on consecutive cycles.
  - Required: the same pcs dequeue in order, each one cycle after its enqueue.
  - Required: `count` never exceeds 1.
- **Fill and drain:** `deq_ready` = 0; offer 10 bundles with pc 0x00..0x24.
  - Required: exactly 8 accepted (pc 0x00..0x1C); `enq_ready` = 0 with `count` = 8.
  - Then raise `deq_ready`. Required: 0x00..0x1C dequeue in order, then 0x20 and 0x24. No pc is lost or duplicated.
- **Wrap-around:** run 20 enqueues with random `deq_ready` (~50%), so pointers wrap at least twice.
  - Required: the dequeued pc sequence equals the enqueued sequence.
  - Required: `count` equals `tail − head` every cycle.
- **Flush while partly full:** load pc 0x10, 0x14, 0x18. Assert `flush` for one cycle with `enq_valid` = 1, pc 0x1C.
  - Required: `count` = 0 and `deq_valid` = 0 next cycle; 0x1C is never dequeued.
  - Then enqueue pc 0x40. Required: 0x40 is the first dequeue, at the next cycle.
- **Simultaneous enqueue/dequeue at full:** `count` = 8, `enq_valid` = `deq_ready` = 1 for one cycle.
  - Required: dequeue only; `count` = 7.
  - Next cycle the enqueue fires with `deq_ready` = 0. Required: `count` = 8.
- **Reset mid-stream:** with `count` = 5, drive `rst_n` = 0 for 2 cycles.
  - Required: outputs are 0 during reset; `count` = 0 afterward.
  - Required: the first post-reset dequeue is the first bundle enqueued after release.
